enc4t2e_seq: RTL and testbench

// - Sequential 4-to-2 request encoder with enable: the encode-side counterpart of the
//   DEC2T4E 2-to-4 decoder. Captures one-cycle request strobes on I0..I3 into a

---
 rtl/enc4t2e_seq.sv | 121 ++++++++++++
 tb/tb_enc4t2e_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/enc4t2e_seq.sv
// Sequential 4-to-2 request encoder: strobes are captured into a pending register and
// granted one index per accept over a valid/ready handshake (fixed priority or round-robin).
module enc4t2e_seq #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic       I0,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  input  logic       Rdy,
  output logic       Y0,
  output logic       Y1,
  output logic       V,
  output logic [3:0] Pend,
  output logic       Ovf
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] p_q, p_d;
  logic [1:0] y_q, y_d;
  logic       v_q, v_d;
  logic       ovf_q, ovf_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] s_s, c_s, r_s;

  // Round-robin scans ptr+1, ptr+2, ... wrapping; fixed priority takes the highest bit.
  function automatic logic [1:0] sel_f(input logic [3:0] m, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    sel_f = 2'd0;
    found = 1'b0;
    if (ROUND_ROBIN != 0) begin
      for (int k = 1; k <= 4; k++) begin
        idx = ptr + k[1:0];
        if (!found && m[idx]) begin
          sel_f = idx;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m[k]) sel_f = k[1:0];
      end
    end
  endfunction

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ptr_d   = ptr_q;
    c_s     = 4'b0000;
    r_s     = p_q;
    s_s     = En ? {I3, I2, I1, I0} : 4'b0000;
    case (state_q)
      IDLE: begin
        if (p_q != 4'b0000) begin
          y_d     = sel_f(p_q, ptr_q);
          state_d = PRESENT;
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (Rdy) begin
          c_s = 4'b0001 << y_q;
          if (ROUND_ROBIN != 0) begin
            ptr_d = y_q;
          end else begin
            ptr_d = ptr_q;
          end
          // Remaining requests exclude strobes arriving this edge.
          r_s = p_q & ~c_s;
          if (r_s != 4'b0000) begin
            y_d     = sel_f(r_s, ptr_d);
            state_d = PRESENT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    p_d   = (p_q & ~c_s) | s_s;
    ovf_d = |(s_s & p_q & ~c_s);
    v_d   = (state_d == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= 4'b0000;
      y_q     <= 2'b00;
      v_q     <= 1'b0;
      ovf_q   <= 1'b0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      y_q     <= y_d;
      v_q     <= v_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Y0   = y_q[0];
  assign Y1   = y_q[1];
  assign V    = v_q;
  assign Pend = p_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_enc4t2e_seq.sv
// Bench for enc4t2e_seq: fixed-priority and round-robin instances share stimulus and are
// compared each cycle with a behavioural model, plus directed constant checks.
module tb_enc4t2e_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, En = 1'b0, I0 = 1'b0, I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, Rdy = 1'b0;
  logic y0_0, y1_0, v_0, ovf_0;
  logic y0_1, y1_1, v_1, ovf_1;
  logic [3:0] pend_0, pend_1;

  enc4t2e_seq #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst(rst), .En(En), .I0(I0), .I1(I1), .I2(I2), .I3(I3), .Rdy(Rdy),
    .Y0(y0_0), .Y1(y1_0), .V(v_0), .Pend(pend_0), .Ovf(ovf_0));

  enc4t2e_seq #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst), .En(En), .I0(I0), .I1(I1), .I2(I2), .I3(I3), .Rdy(Rdy),
    .Y0(y0_1), .Y1(y1_1), .V(v_1), .Pend(pend_1), .Ovf(ovf_1));

  int errs = 0;
  int checks = 0;

  // Model state, index 0 = fixed priority, 1 = round-robin.
  bit mp[2][4];
  int my[2];
  bit mv[2];
  bit movf[2];
  int mptr[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit en, input bit [3:0] req, input bit rdy);
    for (int m = 0; m < 2; m++) begin
      bit avail[4];
      bit s[4];
      bit any;
      int clr;
      int pick;
      clr = -1;
      any = 1'b0;
      pick = -1;
      for (int i = 0; i < 4; i++) s[i] = en && req[i];
      if (r) begin
        for (int i = 0; i < 4; i++) mp[m][i] = 1'b0;
        my[m] = 0; mv[m] = 1'b0; movf[m] = 1'b0; mptr[m] = 3;
      end else begin
        if (mv[m] && rdy) begin
          clr = my[m];
          if (m == 1) mptr[m] = my[m];
        end
        for (int i = 0; i < 4; i++) begin
          avail[i] = mp[m][i] && (i != clr);
          if (avail[i]) any = 1'b1;
        end
        if (!(mv[m] && !rdy)) begin
          if (any) begin
            if (m == 0) begin
              for (int i = 3; i >= 0; i--) if (pick < 0 && avail[i]) pick = i;
            end else begin
              for (int off = 1; off <= 4; off++)
                if (pick < 0 && avail[(mptr[m] + off) % 4]) pick = (mptr[m] + off) % 4;
            end
            my[m] = pick;
            mv[m] = 1'b1;
          end else begin
            mv[m] = 1'b0;
          end
        end
        movf[m] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (s[i] && mp[m][i] && i != clr) movf[m] = 1'b1;
          mp[m][i] = (mp[m][i] && i != clr) || s[i];
        end
      end
    end
  endtask

  function automatic logic [7:0] mexp(input int m);
    logic [3:0] p;
    logic [1:0] y;
    for (int i = 0; i < 4; i++) p[i] = mp[m][i];
    y = my[m][1:0];
    return {y, mv[m], p, movf[m]};
  endfunction

  task automatic step(input bit r, input bit en, input bit [3:0] req, input bit rdy);
    rst = r; En = en; {I3, I2, I1, I0} = req; Rdy = rdy;
    @(posedge clk);
    model_edge(r, en, req, rdy);
    #1;
    check_val("model_fp", {24'd0, y1_0, y0_0, v_0, pend_0, ovf_0}, {24'd0, mexp(0)});
    check_val("model_rr", {24'd0, y1_1, y0_1, v_1, pend_1, ovf_1}, {24'd0, mexp(1)});
  endtask

  initial begin
    logic [1:0] e0;
    logic [1:0] e1;
    #2;
    // Reset with all inputs active
    step(1'b1, 1'b1, 4'hF, 1'b1);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    check_val("reset_fp", {24'd0, y1_0, y0_0, v_0, pend_0, ovf_0}, 32'd0);
    check_val("reset_rr", {24'd0, y1_1, y0_1, v_1, pend_1, ovf_1}, 32'd0);

    // Single request on line 2
    step(1'b0, 1'b1, 4'b0100, 1'b1);
    check_val("single_pend", {28'd0, pend_0}, 32'h4);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("single_grant", {29'd0, v_0, y1_0, y0_0}, 32'h6);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("single_done", {27'd0, v_0, pend_0}, 32'h0);

    // All four lines together
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 4'hF, 1'b1);
    for (int g = 0; g < 4; g++) begin
      step(1'b0, 1'b0, 4'b0000, 1'b1);
      e0 = 2'(3 - g);
      e1 = 2'(g);
      check_val("prio_fp", {29'd0, v_0, y1_0, y0_0}, {29'd0, 1'b1, e0});
      check_val("prio_rr", {29'd0, v_1, y1_1, y0_1}, {29'd0, 1'b1, e1});
    end
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("prio_idle", {30'd0, v_0, v_1}, 32'd0);

    // Lines 1 and 3 together
    step(1'b0, 1'b1, 4'b1010, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("pair1_rr", {30'd0, y1_1, y0_1}, 32'd1);
    check_val("pair1_fp", {30'd0, y1_0, y0_0}, 32'd3);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("pair2_rr", {30'd0, y1_1, y0_1}, 32'd3);
    check_val("pair2_fp", {30'd0, y1_0, y0_0}, 32'd1);
    step(1'b0, 1'b0, 4'b0000, 1'b1);

    // Backpressure with a lost repeat strobe
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 1'b1, (c == 1) ? 4'b0010 : 4'b0000, 1'b0);
      check_val("bp_hold", {29'd0, v_0, y1_0, y0_0}, 32'h5);
      check_val("bp_ovf", {31'd0, ovf_0}, (c == 1) ? 32'd1 : 32'd0);
    end
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("bp_accept", {27'd0, v_0, pend_0}, 32'd0);

    // Disabled capture
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 4'hF, 1'b0);
      check_val("en_off", {28'd0, pend_0}, 32'd0);
    end

    // Re-request on the accept edge
    step(1'b0, 1'b1, 4'b1000, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("rereq_grant", {29'd0, v_0, y1_0, y0_0}, 32'h7);
    step(1'b0, 1'b1, 4'b1000, 1'b1);
    check_val("rereq_keep", {29'd0, pend_0[3], ovf_0, v_0}, 32'h4);
    step(1'b0, 1'b0, 4'b0000, 1'b1);
    check_val("rereq_again", {29'd0, v_0, y1_0, y0_0}, 32'h7);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15) & $urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
